prefetch_queue: RTL
===================

# prefetch_queue

Byte-granular instruction prefetch queue feeding the opcode decoder. It accepts aligned 32-bit code words from the bus/fetch unit and stores them in a circular byte buffer. It presents the oldest four unconsumed bytes as a 4-byte instruction window (`o_instruction[0:3]`), which drives the decoder's `i_instruction[0:3]`. It retires whatever byte count the decode stage reports as consumed each cycle.

## Interface
Parameters:
- `DEPTH`, 16 — queue capacity in bytes. Must be a power of two, at least 8 and a multiple of 4.

Ports:
- `clock`  input  1 — single clock for the block; all state updates on its rising edge.
- `reset`  input  1 — asynchronous, active-high reset.
- `i_flush`  input  1 — discard all contents (jump, fault). Synchronous.
- `i_fetch_valid`  input  1 — `i_fetch_data` holds a code word.
- `i_fetch_data`  input  32 — code word, little-endian; byte 0 is in bits [7:0].
- `i_fetch_skip`  input  2 — leading bytes of the first word after reset/flush to discard (unaligned jump target).
- `o_fetch_ready`  output  1 — space for one word.
- `o_instruction`  output  8 ×[0:3] — byte window; index 0 is the oldest byte.
- `o_valid_count`  output  3 — number of valid window bytes, 0..4.
- `i_consume`  input  3 — bytes retired this cycle, 0..4.
- `o_error`  output  1 — sticky protocol error.

## Operation
- State: `rd_ptr`, `wr_ptr` (log2(DEPTH) bits, wrap modulo DEPTH), `count` (log2(DEPTH)+1 bits), FSM `{ST_ALIGN, ST_RUN}`, `error`.
- `wr_ptr` is always a multiple of 4. A write never overlaps unread bytes.
- Write acceptance: a write happens when `i_fetch_valid & o_fetch_ready`. Bytes go to `mem[wr_ptr..wr_ptr+3]`, then `wr_ptr += 4`.
- ST_ALIGN (after reset/flush): on the first accepted write, `rd_ptr = skip`, `count += 4 - skip`, and the FSM moves to ST_RUN.
- ST_RUN: `i_fetch_skip` is ignored and an accepted write adds 4 to `count`.
- `o_fetch_ready = (count + rd_ptr[1:0]_misalign_free) ≤ DEPTH-4`. In practice this reduces to `(wr_ptr - rd_ptr) mod DEPTH` occupancy ≤ DEPTH-4, with a full queue (count==DEPTH) reporting not ready.
- Window: `o_instruction[k] = mem[rd_ptr+k]` for k < `o_valid_count`; otherwise the byte is 0x00. `o_valid_count = min(count, 4)`.
- Consume: the effective amount is `c = min(i_consume, o_valid_count)`; then `rd_ptr += c` and `count -= c`.
- If `i_consume > o_valid_count`, `error` is set and the consume is clamped to `c`.
- Simultaneous write and consume: `count_next = count + written - c`. Both pointers update in the same cycle.
- Flush: pointers and `count` clear to 0, the FSM goes to ST_ALIGN, and `error` clears. Flush has priority, so a write or consume in the same cycle is dropped.
- Reset asserted mid-operation behaves like flush; stored bytes are cleared to 0.
- Reset values: `o_fetch_ready`=1, `o_valid_count`=0, `o_instruction`=all 0x00, `o_error`=0, FSM = ST_ALIGN.

## Timing
- The window, `o_valid_count` and `o_fetch_ready` are combinational from registered state; no input-to-output paths exist except under the macro below.
- Write at edge N: the bytes are visible in the window from edge N onward (1-cycle latency).
- Consume at edge N: the window shifts after edge N, so the decoder sees the next instruction bytes in cycle N+1.
- After flush, the earliest valid window is the cycle after the first accepted fetch.

## Configuration
- `PREFETCH_QUEUE_BYPASS_EN` defined:
  - When `count==0` and `i_fetch_valid`, the window and `o_valid_count` show the incoming word combinationally. In ST_ALIGN the `i_fetch_skip` offset is applied and valid count is `4 - skip`.
  - Same-cycle `i_consume` against those bytes is legal.
  - Storage still records the unconsumed remainder.
- Undefined: no combinational fetch-to-window path; the 1-cycle latency always applies.

## Structure
- Package `prefetch_queue_pkg`: `DEPTH` default, `byte_t`, `pq_state_t` enum `{ST_ALIGN, ST_RUN}`, `PTR_W`.
- Sub-module `prefetch_queue_window`: a 4-output byte rotator from `mem`, `rd_ptr` and `valid_count`, with zero-fill; it also holds the bypass mux under the macro.

## Test plan
- Reset, then write 0x44332211 with skip 0 → next cycle the window is 11,22,33,44 and `o_valid_count`=4.
- Flush, then write 0xDDCCBBAA with skip 2 → window CC,DD,00,00 with `o_valid_count`=2.
- Four writes with no consume (16 bytes) → `o_fetch_ready`=0. Consume 4 → ready returns in the next cycle. The window wraps correctly across byte 15→0.
- Simultaneous write and consume of 3 with count 6 → count becomes 7 and the window starts at the fourth byte.
- `i_consume`=4 while `o_valid_count`=2 → `o_error`=1 (sticky), only 2 bytes retired. Flush clears error and empties the queue.
- Flush asserted in the same cycle as a valid write → the write is dropped, `o_valid_count`=0 and the FSM is in ST_ALIGN. With `PREFETCH_QUEUE_BYPASS_EN`, an empty queue plus a fetch shows the bytes in the same cycle.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prefetch_queue_pkg : shared types and defaults for the prefetch queue |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package prefetch_queue_pkg;

  localparam int PQ_DEPTH = 16;
  localparam int PTR_W    = $clog2(PQ_DEPTH);

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } pq_state_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_queue_window.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prefetch_queue_window : 4-byte rotator with zero-fill and optional    |
// | fetch bypass (PREFETCH_QUEUE_BYPASS_EN).  Revision 1.0                |
// +-----------------------------------------------------------------------+
module prefetch_queue_window
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PQ_DEPTH
) (
  input  byte_t                    mem_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
  input  logic [2:0]               valid_count_i,
`ifdef PREFETCH_QUEUE_BYPASS_EN
  input  logic                     byp_sel_i,
  input  logic [31:0]              byp_data_i,
  input  logic [1:0]               byp_off_i,
`endif
  output byte_t                    win_o [0:3]
);

  localparam int AW = $clog2(DEPTH);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    byte_t w_stored;
    assign w_stored = mem_i[rd_ptr_i + AW'(k)];
`ifdef PREFETCH_QUEUE_BYPASS_EN
    // Valid count is 4-offset in bypass, so offset+k never exceeds 3 here.
    logic [1:0] w_idx;
    byte_t      w_byp;
    assign w_idx    = byp_off_i + 2'(k);
    assign w_byp    = byp_data_i[{w_idx, 3'b000} +: 8];
    assign win_o[k] = (3'(k) >= valid_count_i) ? 8'h00 :
                      (byp_sel_i ? w_byp : w_stored);
`else
    assign win_o[k] = (3'(k) >= valid_count_i) ? 8'h00 : w_stored;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prefetch_queue : byte-granular instruction prefetch queue; define     |
// | PREFETCH_QUEUE_BYPASS_EN for a same-cycle fetch-to-window path.       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PQ_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_data,
  input  logic [1:0]  i_fetch_skip,
  output logic        o_fetch_ready,
  output byte_t       o_instruction [0:3],
  output logic [2:0]  o_valid_count,
  input  logic [2:0]  i_consume,
  output logic        o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  pq_state_t     state_q, state_d;
  logic          error_q, error_d;
  byte_t         mem_q [DEPTH];

  logic          w_ready;
  logic          w_wr;
  logic [2:0]    w_stored_vc;
  logic [2:0]    w_valid;
  logic          w_over;
  logic [2:0]    w_take;
  logic [AW-1:0] w_rd_base;
  logic [CW-1:0] w_add;

  assign w_ready     = (count_q <= CW'(DEPTH - 4));
  assign w_wr        = i_fetch_valid & w_ready;
  assign w_stored_vc = (count_q >= CW'(4)) ? 3'd4 : count_q[2:0];

`ifdef PREFETCH_QUEUE_BYPASS_EN
  logic       w_byp;
  logic [1:0] w_byp_off;
  assign w_byp     = (count_q == '0) && i_fetch_valid;
  assign w_byp_off = (state_q == ST_ALIGN) ? i_fetch_skip : 2'd0;
  assign w_valid   = w_byp ? (3'd4 - {1'b0, w_byp_off}) : w_stored_vc;
`else
  assign w_valid   = w_stored_vc;
`endif

  // Over-consume is clamped to what the window actually holds.
  assign w_over = (i_consume > w_valid);
  assign w_take = w_over ? w_valid : i_consume;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    error_d   = error_q;
    w_rd_base = rd_ptr_q;
    w_add     = '0;

    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(4);
      if (state_q == ST_ALIGN) begin
        w_rd_base = AW'(i_fetch_skip);
        w_add     = CW'(4) - CW'(i_fetch_skip);
        state_d   = ST_RUN;
      end else begin
        w_add = CW'(4);
      end
    end

    rd_ptr_d = w_rd_base + AW'(w_take);
    count_d  = count_q + w_add - CW'(w_take);
    if (w_over) error_d = 1'b1;

    if (i_flush) begin
      state_d  = ST_ALIGN;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ALIGN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // wr_ptr is word aligned, so only its upper bits select the lane group.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (w_wr && !i_flush) begin
      for (int j = 0; j < 4; j++)
        mem_q[{wr_ptr_q[AW-1:2], 2'(j)}] <= i_fetch_data[8*j +: 8];
    end
  end

  prefetch_queue_window #(
    .DEPTH(DEPTH)
  ) u_window (
    .mem_i         (mem_q),
    .rd_ptr_i      (rd_ptr_q),
    .valid_count_i (w_valid),
`ifdef PREFETCH_QUEUE_BYPASS_EN
    .byp_sel_i     (w_byp),
    .byp_data_i    (i_fetch_data),
    .byp_off_i     (w_byp_off),
`endif
    .win_o         (o_instruction)
  );

  assign o_fetch_ready = w_ready;
  assign o_valid_count = w_valid;
  assign o_error       = error_q;

endmodule
`default_nettype wire
